// File: rtl/mdu.sv
// mdu - multiply/divide unit for the E stage of the pipelined MIPS core.
//
// Executes mult/multu/div/divu with a fixed, parameterised latency and owns the
// architectural HI/LO registers. mthi/mtlo write HI/LO in one edge; mfhi/mflo read
// them combinationally through MDUAns.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   MDUOp     in   0 mult, 1 multu, 2 div, 3 divu, 4 mtlo, 5 mthi, 6 mflo, 7 mfhi
//   MDUStart  in   mult/multu/div/divu command present in E
//   A, B      in   rs / rt operands
//   MDUWrEn   in   valid mthi/mtlo in E
//   Busy      out  operation in flight
//   HI, LO    out  architectural HI/LO
//   MDUAns    out  mfhi/mflo read data (0 for other ops)
//
// Configuration macro:
//   MDU_DIV0_SAT_EN  when defined, divide by zero writes LO=0xFFFFFFFF, HI=A;
//                    otherwise divide by zero leaves HI/LO unchanged.

module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDUOp,
    input  logic        MDUStart,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDUWrEn,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUAns
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] t_hi_q;
    logic [31:0] t_lo_q;

    // Decode
    logic is_div;
    logic signed_op;
    logic start_ok;
    logic b_zero;

    assign is_div    = MDUOp[1];
    assign signed_op = ~MDUOp[0];
    assign start_ok  = MDUStart & ~MDUOp[2];
    assign b_zero    = (B == 32'd0);

    // Multiplier: sign- or zero-extend to 64 bits; the low 64 bits of the
    // product are then correct for both signed and unsigned operands.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_a   = {{32{A[31] & signed_op}}, A};
    assign mul_b   = {{32{B[31] & signed_op}}, B};
    assign product = mul_a * mul_b;

    // Divider: one unsigned divider on magnitudes, signs restored afterwards.
    // This sidesteps the -2^31 / -1 overflow of a native signed divide.
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign neg_a = signed_op & A[31];
    assign neg_b = signed_op & B[31];
    assign abs_a = neg_a ? (~A + 32'd1) : A;
    assign abs_b = neg_b ? (~B + 32'd1) : B;
    // Divisor of zero is replaced so the divider never sees it; result unused.
    assign div_b = b_zero ? 32'd1 : abs_b;
    assign q_mag = abs_a / div_b;
    assign r_mag = abs_a % div_b;
    assign quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

    // Result captured at the start edge
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        res_hi = product[63:32];
        res_lo = product[31:0];
        if (is_div) begin
            if (b_zero) begin
`ifdef MDU_DIV0_SAT_EN
                res_hi = A;
                res_lo = 32'hFFFF_FFFF;
`else
                // Commit current HI/LO back so the registers appear unchanged.
                res_hi = HI;
                res_lo = LO;
`endif
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            t_hi_q  <= 32'd0;
            t_lo_q  <= 32'd0;
            Busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        t_hi_q  <= res_hi;
                        t_lo_q  <= res_lo;
                        cnt_q   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        Busy    <= 1'b1;
                        state_q <= StBusy;
                    end else if (MDUWrEn) begin
                        if (MDUOp == 3'd5) HI <= A;
                        if (MDUOp == 3'd4) LO <= A;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        HI      <= t_hi_q;
                        LO      <= t_lo_q;
                        Busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        MDUAns = 32'd0;
        if (MDUOp == 3'd7) MDUAns = HI;
        if (MDUOp == 3'd6) MDUAns = LO;
    end

endmodule
